// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns one CPU load/store request at a time into word-wide accesses to a
//   synchronous memory (registered read, read-before-write). Sub-word stores
//   use read-modify-write. Misaligned or illegal-size requests get an error
//   response and never touch memory.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready only while idle)
//   i_req_we                 1 = store, 0 = load
//   i_req_size               00 byte, 01 half, 10 word, 11 illegal
//   i_req_signed             sign-extend sub-word loads
//   i_req_addr, i_req_wdata  byte address, right-justified store data
//   o_rsp_valid              one-cycle response pulse
//   o_rsp_rdata, o_rsp_error load result / error flag for the response
//   o_mem_address            word-aligned memory address
//   o_mem_we, o_mem_wr_data  memory write strobe and write word
//   i_mem_rd_data            memory read word, one cycle after the address
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic [31:0] o_mem_address,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wr_data,
  input  logic [31:0] i_mem_rd_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, DATA, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        accept;
  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign accept  = i_req_valid && (state_q == IDLE);
  assign req_err = (i_req_size == 2'b11) ||
                   ((i_req_size == 2'b01) && i_req_addr[0]) ||
                   ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));

  // Bit offset of the addressed lane; halfwords are aligned, so the same
  // shift serves both byte and half accesses.
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign shifted = i_mem_rd_data >> lane_sh;

  always_comb begin
    load_val = i_mem_rd_data;
    case (size_q)
      2'b00:   load_val = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h000000, shifted[7:0]};
      2'b01:   load_val = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'h0000, shifted[15:0]};
      default: load_val = i_mem_rd_data;
    endcase
  end

  // wr_data_q still holds the right-justified store data while in DATA,
  // so it is shifted into the addressed lane(s) here.
  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign merged    = (i_mem_rd_data & ~lane_mask) | ((wr_data_q << lane_sh) & lane_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= 32'h0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      wr_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_req_valid) state_d = req_err ? RESP : ISSUE;
      ISSUE:   state_d = (we_q && (size_q == 2'b10)) ? RESP : DATA;
      DATA:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured only on accept; rdata is cleared then so
  // stores and errors answer with zero.
  always_comb begin
    we_d      = we_q;
    size_d    = size_q;
    signed_d  = signed_q;
    addr_d    = addr_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      we_d      = i_req_we;
      size_d    = i_req_size;
      signed_d  = i_req_signed;
      addr_d    = i_req_addr;
      err_d     = req_err;
      rdata_d   = 32'h0;
      wr_data_d = i_req_wdata;
    end else if (state_q == DATA) begin
      if (we_q) wr_data_d = merged;
      else      rdata_d   = load_val;
    end
  end

  always_comb begin
    o_req_ready   = (state_q == IDLE);
    o_rsp_valid   = (state_q == RESP);
    o_rsp_error   = (state_q == RESP) && err_q;
    o_mem_we      = ((state_q == ISSUE) && we_q && (size_q == 2'b10)) || (state_q == WRITE);
    o_rsp_rdata   = rdata_q;
    o_mem_address = {addr_q[31:2], 2'b00};
    o_mem_wr_data = wr_data_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Drives directed requests into load_store_unit, hosts a word memory with
//   registered read, and checks every cycle against a byte-addressed
//   request-level model of the unit. A few literal expectations pin the model.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_error;
  logic [31:0] o_mem_address;
  logic        o_mem_we;
  logic [31:0] o_mem_wr_data;
  logic [31:0] i_mem_rd_data;

  int checks   = 0;
  int failures = 0;

  load_store_unit dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_we      (i_req_we),
    .i_req_size    (i_req_size),
    .i_req_signed  (i_req_signed),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_error   (o_rsp_error),
    .o_mem_address (o_mem_address),
    .o_mem_we      (o_mem_we),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_rd_data (i_mem_rd_data)
  );

  always #5 i_clk = ~i_clk;

  // Memory behind the unit: registered read, read-before-write. Preloads
  // come in through pre_en so this block is the only writer of hmem.
  logic [31:0] hmem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge i_clk) begin
    if (pre_en)        hmem[pre_idx] <= pre_val;
    else if (o_mem_we) hmem[o_mem_address[7:2]] <= o_mem_wr_data;
    i_mem_rd_data <= hmem[o_mem_address[7:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Request-level model: memory seen as bytes, one outstanding request,
  // response/write cycles derived from the request kind.
  logic [7:0]  shadow [0:255];
  int          cyc = 0;
  bit          pend = 1'b0;
  int          due_rsp, due_we;
  logic [31:0] exp_rdata, exp_wdata, exp_waddr;
  logic        exp_err;
  bit          has_write;
  logic [7:0]  cbase;
  logic [7:0]  cbytes [4];

  task automatic modelAccept();
    logic [7:0] a, base;
    logic [7:0] wb [4];
    logic       err;
    a    = i_req_addr[7:0];
    base = {a[7:2], 2'b00};
    err  = (i_req_size == 2'b11) || ((i_req_size == 2'b01) && a[0]) ||
           ((i_req_size == 2'b10) && (a[1:0] != 2'b00));
    pend      = 1'b1;
    exp_err   = err;
    exp_rdata = 32'h0;
    has_write = 1'b0;
    if (err) begin
      due_rsp = cyc + 1;
    end else if (!i_req_we) begin
      due_rsp = cyc + 3;
      case (i_req_size)
        2'b00: exp_rdata = i_req_signed ? {{24{shadow[a][7]}}, shadow[a]} : {24'h0, shadow[a]};
        2'b01: exp_rdata = i_req_signed ? {{16{shadow[a + 8'd1][7]}}, shadow[a + 8'd1], shadow[a]}
                                        : {16'h0, shadow[a + 8'd1], shadow[a]};
        default: exp_rdata = {shadow[base + 8'd3], shadow[base + 8'd2], shadow[base + 8'd1], shadow[base]};
      endcase
    end else begin
      for (int i = 0; i < 4; i++) wb[i] = shadow[base + 8'(i)];
      if (i_req_size == 2'b10) begin
        for (int i = 0; i < 4; i++) wb[i] = i_req_wdata[8*i +: 8];
        due_we  = cyc + 1;
        due_rsp = cyc + 2;
      end else begin
        wb[a[1:0]] = i_req_wdata[7:0];
        if (i_req_size == 2'b01) wb[a[1:0] + 2'd1] = i_req_wdata[15:8];
        due_we  = cyc + 3;
        due_rsp = cyc + 4;
      end
      exp_wdata = {wb[3], wb[2], wb[1], wb[0]};
      exp_waddr = {i_req_addr[31:2], 2'b00};
      has_write = 1'b1;
      cbase     = base;
      for (int i = 0; i < 4; i++) cbytes[i] = wb[i];
    end
  endtask

  // Compare process: checks the outputs on every cycle against the model.
  always @(negedge i_clk) begin
    cyc++;
    if (pre_en)
      for (int i = 0; i < 4; i++) shadow[{pre_idx, 2'b00} + 8'(i)] = pre_val[8*i +: 8];
    if (!i_rst_n) begin
      pend = 1'b0;
      checkOutput("rst_ready",   {31'h0, o_req_ready}, 32'h1);
      checkOutput("rst_valid",   {31'h0, o_rsp_valid}, 32'h0);
      checkOutput("rst_error",   {31'h0, o_rsp_error}, 32'h0);
      checkOutput("rst_rdata",   o_rsp_rdata, 32'h0);
      checkOutput("rst_mem_we",  {31'h0, o_mem_we}, 32'h0);
      checkOutput("rst_addr",    o_mem_address, 32'h0);
      checkOutput("rst_wr_data", o_mem_wr_data, 32'h0);
    end else begin
      checkOutput("ready",     {31'h0, o_req_ready}, {31'h0, !pend});
      checkOutput("rsp_valid", {31'h0, o_rsp_valid}, {31'h0, pend && (cyc == due_rsp)});
      checkOutput("mem_we",    {31'h0, o_mem_we},    {31'h0, pend && has_write && (cyc == due_we)});
      if (pend && has_write && (cyc == due_we)) begin
        checkOutput("wr_addr", o_mem_address, exp_waddr);
        checkOutput("wr_data", o_mem_wr_data, exp_wdata);
      end
      if (pend && (cyc == due_rsp)) begin
        checkOutput("rsp_rdata", o_rsp_rdata, exp_rdata);
        checkOutput("rsp_error", {31'h0, o_rsp_error}, {31'h0, exp_err});
        if (has_write)
          for (int i = 0; i < 4; i++) shadow[cbase + 8'(i)] = cbytes[i];
        pend = 1'b0;
      end
      if (i_req_valid && o_req_ready) begin
        if (pend) checkOutput("accept_while_busy", 32'h1, 32'h0);
        modelAccept();
      end
    end
  end

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    pre_idx = addr[7:2];
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge i_clk); #1;
    pre_en  = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                               output logic [31:0] rd, output logic er, output int lat);
    bit got;
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_size   = size;
    i_req_signed = sgn;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      if (o_req_ready) got = 1'b1;
    end
    if (!got) checkOutput("accept_timeout", 32'h0, 32'h1);
    @(posedge i_clk); #1;
    if (!hold) i_req_valid = 1'b0;
    lat = 0;
    rd  = 32'hX;
    er  = 1'bX;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        lat = k;
        rd  = o_rsp_rdata;
        er  = o_rsp_error;
      end
    end
    if (lat == 0) checkOutput("rsp_timeout", 32'h0, 32'h1);
    @(posedge i_clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    i_rst_n      = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_size   = 2'b00;
    i_req_signed = 1'b0;
    i_req_addr   = 32'h0;
    i_req_wdata  = 32'h0;
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("lit_reset_ready", {31'h0, o_req_ready}, 32'h1);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] word store then word load");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
    checkOutput("lit_sw_lat", lat, 2);
    checkOutput("lit_sw_mem", hmem[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_lw_lat", lat, 3);
    checkOutput("lit_lw_rdata", rd, 32'hDEADBEEF);
    checkOutput("lit_lw_err", {31'h0, er}, 32'h0);

    $display("[TB] byte store read-modify-write");
    preload(32'h20, 32'h11223344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 1'b0, rd, er, lat);
    checkOutput("lit_sb_lat", lat, 4);
    checkOutput("lit_sb_mem", hmem[8], 32'h1122AA44);

    $display("[TB] sub-word loads");
    preload(32'h20, 32'h8000F0FF);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_lb_signed", rd, 32'hFFFFFFFF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_lhu", rd, 32'h00008000);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_lh_signed", rd, 32'hFFFF8000);

    $display("[TB] error requests");
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_err_half_lat", lat, 1);
    checkOutput("lit_err_half_err", {31'h0, er}, 32'h1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 1'b0, rd, er, lat);
    checkOutput("lit_err_sw_err", {31'h0, er}, 32'h1);
    checkOutput("lit_err_sw_mem", hmem[8], 32'h8000F0FF);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_err_size_rdata", rd, 32'h0);
    checkOutput("lit_err_size_err", {31'h0, er}, 32'h1);

    $display("[TB] half store and more lane loads");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555BEEF, 1'b0, rd, er, lat);
    checkOutput("lit_sh_mem", hmem[8], 32'hBEEFF0FF);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_lbu_lane3", rd, 32'h000000BE);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_lb_lane1", rd, 32'hFFFFFFF0);

    $display("[TB] reset during byte store");
    preload(32'h30, 32'h55667788);
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_size   = 2'b00;
    i_req_signed = 1'b0;
    i_req_addr   = 32'h32;
    i_req_wdata  = 32'h99;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    checkOutput("lit_abort_mem", hmem[12], 32'h55667788);
    checkOutput("lit_abort_ready", {31'h0, o_req_ready}, 32'h1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_after_rst_lat", lat, 3);
    checkOutput("lit_after_rst_rdata", rd, 32'h55667788);

    $display("[TB] back-to-back requests");
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
    checkOutput("lit_b2b_lw", rd, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 1'b1, rd, er, lat);
    checkOutput("lit_b2b_sh_mem", hmem[4], 32'h1234BEEF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, rd, er, lat);
    checkOutput("lit_b2b_lh", rd, 32'h00001234);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, lat);
    checkOutput("lit_b2b_err", {31'h0, er}, 32'h1);

    repeat (3) @(posedge i_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
